// File: rtl/corrode_block_gen.sv
`default_nettype none
// ============================================================================
// Module      : corrode_block_gen
// Description : Tiles the active picture window of a binarized pixel stream
//               into BS x BS blocks and erodes each block to a single bit
//               (1 = block kept white, 0 = corroded). One result strobe is
//               produced per block, in raster block order, one clock after
//               the block's last pixel. The strobe/data pair feeds the
//               display stage's RAM write port directly.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   sys_clk_1     in   1   camera-domain clock
//   sys_rst_n_1   in   1   asynchronous active-low reset
//   i_sof         in   1   one-cycle start-of-frame pulse
//   i_valid       in   1   pixel strobe
//   i_bin         in   1   binarized pixel, 1 = white
//   o_valid       out  1   one-cycle block-result strobe
//   o_wb          out  1   block result, 1 = white/kept, 0 = corroded
//   o_blk_idx     out  11  raster index of the block on o_wb
//   o_frame_done  out  1   pulse coincident with the last block of a frame
// ----------------------------------------------------------------------------
// Build option
//   CORRODE_BLOCK_THRESH_EN : when defined, a block is reported white while
//                             its black-pixel count is <= THRESH (tolerant
//                             erosion). When undefined, a single black pixel
//                             corrodes the block and THRESH is unused.
// ============================================================================
module corrode_block_gen #(
    parameter int P_W    = 12,
    parameter int IMG_X  = 640,
    parameter int IMG_Y  = 480,
    parameter int WIN_X1 = 64,
    parameter int WIN_X2 = 575,
    parameter int WIN_Y1 = 48,
    parameter int WIN_Y2 = 431,
    parameter int BS     = 16,
    parameter int C_L    = 32,
    parameter int C_R    = 24,
    parameter int THRESH = 8
) (
    input  logic        sys_clk_1,
    input  logic        sys_rst_n_1,
    input  logic        i_sof,
    input  logic        i_valid,
    input  logic        i_bin,
    output logic        o_valid,
    output logic        o_wb,
    output logic [10:0] o_blk_idx,
    output logic        o_frame_done
);

    // ------------------------------------------------------------------------
    // Derived widths and typed constants
    // ------------------------------------------------------------------------
    localparam int c_X0_W  = (BS  > 1) ? $clog2(BS)  : 1;
    localparam int c_X1_W  = (C_L > 1) ? $clog2(C_L) : 1;
    localparam int c_ACC_W = $clog2(BS * BS) + 1;
    localparam int c_IDX_W = 11;

    localparam logic [P_W-1:0]     c_X_LAST   = P_W'(IMG_X - 1);
    localparam logic [P_W-1:0]     c_Y_LAST   = P_W'(IMG_Y - 1);
    localparam logic [P_W-1:0]     c_WIN_X1   = P_W'(WIN_X1);
    localparam logic [P_W-1:0]     c_WIN_X2   = P_W'(WIN_X2);
    localparam logic [P_W-1:0]     c_WIN_Y1   = P_W'(WIN_Y1);
    localparam logic [P_W-1:0]     c_WIN_Y2   = P_W'(WIN_Y2);
    localparam logic [c_X0_W-1:0]  c_X0_LAST  = c_X0_W'(BS - 1);
    localparam logic [c_X1_W-1:0]  c_X1_LAST  = c_X1_W'(C_L - 1);
    localparam logic [c_ACC_W-1:0] c_ACC_MAX  = c_ACC_W'(BS * BS);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(C_L * C_R - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [P_W-1:0]     r_cnt_x;
    logic [P_W-1:0]     r_cnt_y;
    logic [c_X0_W-1:0]  r_x0;          // column inside the current block
    logic [c_X1_W-1:0]  r_x1;          // block column
    logic [c_X0_W-1:0]  r_y0;          // row inside the current block row
    logic [c_IDX_W-1:0] r_idx;         // index of the next block to finish
    logic [c_ACC_W-1:0] r_acc [C_L];   // black-pixel count per block column

    logic               r_valid;
    logic               r_wb;
    logic [c_IDX_W-1:0] r_blk_idx;
    logic               r_frame_done;

    // ------------------------------------------------------------------------
    // Effective current state: a start-of-frame pulse makes this cycle's
    // pixel (if any) behave as pixel (0,0) of a clean frame, so every
    // counter and the accumulator read are zeroed before use.
    // ------------------------------------------------------------------------
    logic [P_W-1:0]     w_px;
    logic [P_W-1:0]     w_py;
    logic [c_X0_W-1:0]  w_x0;
    logic [c_X1_W-1:0]  w_x1;
    logic [c_X0_W-1:0]  w_y0;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_ACC_W-1:0] w_acc_cur;

    always_comb begin
        w_px      = i_sof ? '0 : r_cnt_x;
        w_py      = i_sof ? '0 : r_cnt_y;
        w_x0      = i_sof ? '0 : r_x0;
        w_x1      = i_sof ? '0 : r_x1;
        w_y0      = i_sof ? '0 : r_y0;
        w_idx     = i_sof ? '0 : r_idx;
        w_acc_cur = i_sof ? '0 : r_acc[w_x1];
    end

    // ------------------------------------------------------------------------
    // Pixel classification
    // ------------------------------------------------------------------------
    logic w_in_win;
    logic w_frame_end;
    logic w_blk_done;
    logic w_black;

    assign w_in_win    = i_valid
                       && (w_px >= c_WIN_X1) && (w_px <= c_WIN_X2)
                       && (w_py >= c_WIN_Y1) && (w_py <= c_WIN_Y2);
    assign w_frame_end = i_valid && (w_px == c_X_LAST) && (w_py == c_Y_LAST);
    assign w_blk_done  = w_in_win && (w_x0 == c_X0_LAST) && (w_y0 == c_X0_LAST);
    assign w_black     = ~i_bin;

    // Count including this pixel; saturates so it can never roll over.
    logic [c_ACC_W-1:0] w_acc_sum;
    assign w_acc_sum = (w_black && (w_acc_cur != c_ACC_MAX))
                     ? w_acc_cur + 1'b1 : w_acc_cur;

    logic w_blk_wb;
`ifdef CORRODE_BLOCK_THRESH_EN
    localparam logic [c_ACC_W-1:0] c_THRESH = c_ACC_W'(THRESH);
    assign w_blk_wb = (w_acc_sum <= c_THRESH);
`else
    assign w_blk_wb = (w_acc_sum == '0);
`endif

    // ------------------------------------------------------------------------
    // Next-state logic for position and block counters
    // ------------------------------------------------------------------------
    logic [P_W-1:0]     w_cnt_x_nxt;
    logic [P_W-1:0]     w_cnt_y_nxt;
    logic [c_X0_W-1:0]  w_x0_nxt;
    logic [c_X1_W-1:0]  w_x1_nxt;
    logic [c_X0_W-1:0]  w_y0_nxt;
    logic [c_IDX_W-1:0] w_idx_nxt;

    always_comb begin
        w_cnt_x_nxt = w_px;
        w_cnt_y_nxt = w_py;
        w_x0_nxt    = w_x0;
        w_x1_nxt    = w_x1;
        w_y0_nxt    = w_y0;
        w_idx_nxt   = w_idx;

        if (i_valid) begin
            if (w_px == c_X_LAST) begin
                w_cnt_x_nxt = '0;
                w_cnt_y_nxt = (w_py == c_Y_LAST) ? '0 : w_py + 1'b1;
            end else begin
                w_cnt_x_nxt = w_px + 1'b1;
            end
        end

        // Same nesting as the downstream read addressing: x0 innermost,
        // then block column, then row within the block row.
        if (w_in_win) begin
            if (w_x0 == c_X0_LAST) begin
                w_x0_nxt = '0;
                if (w_x1 == c_X1_LAST) begin
                    w_x1_nxt = '0;
                    w_y0_nxt = (w_y0 == c_X0_LAST) ? '0 : w_y0 + 1'b1;
                end else begin
                    w_x1_nxt = w_x1 + 1'b1;
                end
            end else begin
                w_x0_nxt = w_x0 + 1'b1;
            end
        end

        if (w_blk_done) begin
            w_idx_nxt = (w_idx == c_IDX_LAST) ? '0 : w_idx + 1'b1;
        end

        // Natural frame wrap restarts block tracking exactly like i_sof.
        if (w_frame_end) begin
            w_x0_nxt  = '0;
            w_x1_nxt  = '0;
            w_y0_nxt  = '0;
            w_idx_nxt = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk_1 or negedge sys_rst_n_1) begin
        if (!sys_rst_n_1) begin
            r_cnt_x <= '0;
            r_cnt_y <= '0;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_idx   <= '0;
        end else begin
            r_cnt_x <= w_cnt_x_nxt;
            r_cnt_y <= w_cnt_y_nxt;
            r_x0    <= w_x0_nxt;
            r_x1    <= w_x1_nxt;
            r_y0    <= w_y0_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Accumulator bank. The entry selected by an in-window pixel takes the
    // updated count, or clears when its block completes so the block row
    // below starts from zero. A start-of-frame pulse clears the others.
    always_ff @(posedge sys_clk_1 or negedge sys_rst_n_1) begin
        if (!sys_rst_n_1) begin
            for (int i = 0; i < C_L; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < C_L; i++) begin
                if (w_frame_end) begin
                    r_acc[i] <= '0;
                end else if (w_in_win && (w_x1 == c_X1_W'(i))) begin
                    r_acc[i] <= w_blk_done ? '0 : w_acc_sum;
                end else if (i_sof) begin
                    r_acc[i] <= '0;
                end
            end
        end
    end

    // Result registers: o_wb and o_blk_idx hold between strobes.
    always_ff @(posedge sys_clk_1 or negedge sys_rst_n_1) begin
        if (!sys_rst_n_1) begin
            r_valid      <= 1'b0;
            r_wb         <= 1'b0;
            r_blk_idx    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid      <= w_blk_done;
            r_frame_done <= w_blk_done && (w_idx == c_IDX_LAST);
            if (w_blk_done) begin
                r_wb      <= w_blk_wb;
                r_blk_idx <= w_idx;
            end
        end
    end

    assign o_valid      = r_valid;
    assign o_wb         = r_wb;
    assign o_blk_idx    = r_blk_idx;
    assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_corrode_block_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_corrode_block_gen
// Description : Self-checking bench for corrode_block_gen. Uses a reduced
//               picture geometry so whole frames stay short. Each frame is a
//               generated image; expected block results come from counting
//               black pixels over each block's rectangle in that image, and
//               expected strobes from the pixel coordinates alone.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_corrode_block_gen;

    localparam int P_W    = 12;
    localparam int IMG_X  = 40;
    localparam int IMG_Y  = 24;
    localparam int WIN_X1 = 4;
    localparam int WIN_X2 = 35;
    localparam int WIN_Y1 = 2;
    localparam int WIN_Y2 = 17;
    localparam int BS     = 4;
    localparam int C_L    = 8;
    localparam int C_R    = 4;
    localparam int THRESH = 8;
    localparam int NBLK   = C_L * C_R;

    logic        sys_clk_1   = 1'b0;
    logic        sys_rst_n_1 = 1'b0;
    logic        i_sof       = 1'b0;
    logic        i_valid     = 1'b0;
    logic        i_bin       = 1'b1;
    logic        o_valid;
    logic        o_wb;
    logic [10:0] o_blk_idx;
    logic        o_frame_done;

    corrode_block_gen #(
        .P_W(P_W), .IMG_X(IMG_X), .IMG_Y(IMG_Y),
        .WIN_X1(WIN_X1), .WIN_X2(WIN_X2), .WIN_Y1(WIN_Y1), .WIN_Y2(WIN_Y2),
        .BS(BS), .C_L(C_L), .C_R(C_R), .THRESH(THRESH)
    ) dut (
        .sys_clk_1    (sys_clk_1),
        .sys_rst_n_1  (sys_rst_n_1),
        .i_sof        (i_sof),
        .i_valid      (i_valid),
        .i_bin        (i_bin),
        .o_valid      (o_valid),
        .o_wb         (o_wb),
        .o_blk_idx    (o_blk_idx),
        .o_frame_done (o_frame_done)
    );

    always #5 sys_clk_1 = ~sys_clk_1;

    int checks = 0;
    int errors = 0;

    bit img  [IMG_Y][IMG_X];   // current frame, 1 = white
    int bcnt [C_R][C_L];       // black pixels per block of img

    int mx, my;                // position of the next pixel in the frame
    int last_wb, last_idx;     // values the held outputs must show
    int nv, nfd, ev, efd;      // observed / expected strobes in a frame

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_wb(input int black);
`ifdef CORRODE_BLOCK_THRESH_EN
        return (black <= THRESH) ? 1 : 0;
`else
        return (black == 0) ? 1 : 0;
`endif
    endfunction

    // density 0 = all white, otherwise a pixel is black with chance 1/density
    task automatic fill(input int density);
        for (int y = 0; y < IMG_Y; y++)
            for (int x = 0; x < IMG_X; x++)
                img[y][x] = (density == 0) ? 1'b1 : ($urandom_range(density - 1) != 0);
    endtask

    task automatic compute_bcnt();
        for (int by = 0; by < C_R; by++)
            for (int bx = 0; bx < C_L; bx++) begin
                int s = 0;
                for (int yy = 0; yy < BS; yy++)
                    for (int xx = 0; xx < BS; xx++)
                        if (!img[WIN_Y1 + by*BS + yy][WIN_X1 + bx*BS + xx]) s++;
                bcnt[by][bx] = s;
            end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; last_wb = 0; last_idx = 0;
    endtask

    // One clock: drive inputs, then check outputs just after the edge.
    task automatic step(input bit sof, input bit vld);
        int e_v, e_fd, rx, ry, bx, by, idx;
        if (sof) begin mx = 0; my = 0; end
        i_sof   = sof;
        i_valid = vld;
        i_bin   = vld ? img[my][mx] : 1'($urandom_range(1));
        @(posedge sys_clk_1); #1;
        i_sof   = 1'b0;
        i_valid = 1'b0;
        e_v = 0; e_fd = 0;
        if (vld) begin
            rx = mx - WIN_X1;
            ry = my - WIN_Y1;
            if (rx >= 0 && rx < C_L*BS && ry >= 0 && ry < C_R*BS &&
                rx % BS == BS-1 && ry % BS == BS-1) begin
                bx = rx / BS; by = ry / BS;
                idx = by * C_L + bx;
                e_v = 1; e_fd = (idx == NBLK-1) ? 1 : 0;
                last_idx = idx;
                last_wb  = exp_wb(bcnt[by][bx]);
                ev++; efd += e_fd;
            end
            mx++;
            if (mx == IMG_X) begin
                mx = 0; my++;
                if (my == IMG_Y) my = 0;
            end
        end
        chk("valid",      32'(o_valid),      32'(e_v));
        chk("wb",         32'(o_wb),         32'(last_wb));
        chk("blk_idx",    32'(o_blk_idx),    32'(last_idx));
        chk("frame_done", 32'(o_frame_done), 32'(e_fd));
        if (o_valid === 1'b1) nv++;
        if (o_frame_done === 1'b1) nfd++;
    endtask

    // Streams img from the model's position; stops before (stop_y, stop_x).
    task automatic run_frame(input bit use_sof, input int stop_y, input int stop_x, input bit gaps);
        int n = 0;
        compute_bcnt();
        nv = 0; nfd = 0; ev = 0; efd = 0;
        begin : stream
            for (int y = 0; y < IMG_Y; y++)
                for (int x = 0; x < IMG_X; x++) begin
                    if (y == stop_y && x == stop_x) disable stream;
                    if (gaps) begin
                        n++;
                        if (n % 3 == 0) step(1'b0, 1'b0);
                    end
                    step(use_sof && y == 0 && x == 0, 1'b1);
                end
        end
        chk("n_valid", 32'(nv), 32'(ev));
        chk("n_frame_done", 32'(nfd), 32'(efd));
    endtask

    task automatic async_reset_check();
        #2 sys_rst_n_1 = 1'b0;
        #1;
        chk("rst_valid",      32'(o_valid),      32'd0);
        chk("rst_wb",         32'(o_wb),         32'd0);
        chk("rst_blk_idx",    32'(o_blk_idx),    32'd0);
        chk("rst_frame_done", 32'(o_frame_done), 32'd0);
        repeat (2) @(posedge sys_clk_1);
        #1 sys_rst_n_1 = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        fill(0);
        compute_bcnt();

        // Reset state
        repeat (3) @(posedge sys_clk_1);
        #1;
        chk("reset_valid",      32'(o_valid),      32'd0);
        chk("reset_wb",         32'(o_wb),         32'd0);
        chk("reset_blk_idx",    32'(o_blk_idx),    32'd0);
        chk("reset_frame_done", 32'(o_frame_done), 32'd0);
        sys_rst_n_1 = 1'b1;
        step(1'b0, 1'b0);

        // All-white frame
        fill(0);
        run_frame(1'b1, IMG_Y, 0, 1'b0);
        chk("white_count", 32'(nv), 32'(NBLK));

        // Single black pixel inside block 1
        fill(0);
        img[WIN_Y1 + 3][WIN_X1 + BS + 1] = 1'b0;
        run_frame(1'b1, IMG_Y, 0, 1'b0);

        // Single black pixel on the completing pixel of block C_L+1
        fill(0);
        img[WIN_Y1 + 2*BS - 1][WIN_X1 + 2*BS - 1] = 1'b0;
        run_frame(1'b1, IMG_Y, 0, 1'b0);

        // Random image with an idle cycle every third cycle
        fill(40);
        run_frame(1'b1, IMG_Y, 0, 1'b1);

        // Random frame followed by a frame that starts by natural wrap
        fill(30);
        run_frame(1'b1, IMG_Y, 0, 1'b0);
        fill(30);
        run_frame(1'b0, IMG_Y, 0, 1'b0);

        // Threshold boundary: block 0 has THRESH black, block 1 THRESH+1
        fill(50);
        for (int k = 0; k < BS*BS; k++) begin
            img[WIN_Y1 + k/BS][WIN_X1 + k%BS]      = (k >= THRESH);
            img[WIN_Y1 + k/BS][WIN_X1 + BS + k%BS] = (k >= THRESH + 1);
        end
        run_frame(1'b1, IMG_Y, 0, 1'b0);

        // Truncated dense frame, lone i_sof, then clean frame (no residue)
        fill(3);
        run_frame(1'b1, WIN_Y1 + BS + 2, 10, 1'b0);
        step(1'b1, 1'b0);
        fill(0);
        run_frame(1'b0, IMG_Y, 0, 1'b0);
        chk("no_residue_count", 32'(nv), 32'(NBLK));

        // Truncated frame restarted by i_sof together with a pixel
        fill(3);
        run_frame(1'b1, WIN_Y1 + BS + 1, 20, 1'b0);
        fill(25);
        run_frame(1'b1, IMG_Y, 0, 1'b0);

        // Asynchronous reset mid-block, then a frame without i_sof
        fill(0);
        run_frame(1'b1, WIN_Y1 + BS + 2, 12, 1'b0);
        async_reset_check();
        fill(40);
        run_frame(1'b0, IMG_Y, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
